mem_access_ctrl: RTL and testbench

- Sequences MEM-stage load/store instructions onto a single-port data RAM that uses an addr_ok/data_ok handshake.
- Stalls the pipeline until each access completes.
- Generates byte write strobes and store-data replication, aligns and extends load data, and flags misaligned accesses (AdEL/AdES).
- Sits between the MEM stage and the data-RAM bridge.

---
 rtl/mem_access_ctrl_pkg.sv | 59 +++++
 rtl/mem_access_ctrl_load_align.sv | 39 +++
 rtl/mem_access_ctrl.sv | 159 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: load/store opcodes, FSM state encoding and store-side helpers
// Revision: 1.0
`default_nettype none

package mem_access_ctrl_pkg;

    localparam logic [5:0] EXE_LB  = 6'b100000;
    localparam logic [5:0] EXE_LH  = 6'b100001;
    localparam logic [5:0] EXE_LW  = 6'b100011;
    localparam logic [5:0] EXE_LBU = 6'b100100;
    localparam logic [5:0] EXE_LHU = 6'b100101;
    localparam logic [5:0] EXE_SB  = 6'b101000;
    localparam logic [5:0] EXE_SH  = 6'b101001;
    localparam logic [5:0] EXE_SW  = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_load(input logic [5:0] op);
        return (op == EXE_LB) || (op == EXE_LBU) || (op == EXE_LH) ||
               (op == EXE_LHU) || (op == EXE_LW);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == EXE_SB) || (op == EXE_SH) || (op == EXE_SW);
    endfunction

    function automatic logic misaligned(input logic [5:0] op, input logic [1:0] off);
        case (op)
            EXE_LH, EXE_LHU, EXE_SH: return off[0];
            EXE_LW, EXE_SW:          return off != 2'b00;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(input logic [5:0] op, input logic [1:0] off);
        case (op)
            EXE_SB:  return 4'b0001 << off;
            EXE_SH:  return off[1] ? 4'b1100 : 4'b0011;
            EXE_SW:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [5:0] op, input logic [31:0] wdata);
        case (op)
            EXE_SB:  return {4{wdata[7:0]}};
            EXE_SH:  return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_ctrl_load_align.sv
// mem_access_ctrl_load_align: selects the addressed byte/halfword of a RAM word and extends it
// Revision: 1.0
`default_nettype none

module mem_access_ctrl_load_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] raw,
    output logic [31:0] result
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = 8'h00;
        case (off)
            2'd0: sel_byte = raw[7:0];
            2'd1: sel_byte = raw[15:8];
            2'd2: sel_byte = raw[23:16];
            2'd3: sel_byte = raw[31:24];
            default: sel_byte = raw[7:0];
        endcase
        sel_half = off[1] ? raw[31:16] : raw[15:0];

        case (op)
            EXE_LB:  result = {{24{sel_byte[7]}}, sel_byte};
            EXE_LBU: result = {24'h000000, sel_byte};
            EXE_LH:  result = {{16{sel_half[15]}}, sel_half};
            EXE_LHU: result = {16'h0000, sel_half};
            default: result = raw;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MEM-stage loads/stores onto an addr_ok/data_ok data RAM
// Revision: 1.0
`default_nettype none

module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 255
)(
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_req,
    input  logic [5:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        adel,
    output logic        ades,
    output logic [31:0] bad_vaddr,
    output logic        bus_err,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic        ram_addr_ok,
    input  logic        ram_data_ok,
    input  logic [31:0] ram_rdata
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state, state_nx;
    logic [5:0]  op_q;
    logic [1:0]  off_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  we_q;
    logic        discard, discard_nx;
    logic [7:0]  wd_cnt;
    logic        bus_err_nx;
    logic        load_done;
    logic [31:0] aligned;

    logic req_ok, mis, start, timeout, drop;

    // resetn gates the request path so combinational outputs stay low during reset
    assign req_ok  = resetn && mem_req && (is_load(op) || is_store(op)) && !flush
                     && (state == ST_IDLE);
    assign mis     = misaligned(op, addr[1:0]);
    assign start   = req_ok && !mis;
    assign timeout = (wd_cnt == WAIT_LAST);
    assign drop    = discard || flush;

    assign adel        = req_ok && mis && is_load(op);
    assign ades        = req_ok && mis && is_store(op);
    assign bad_vaddr   = (adel || ades) ? addr : 32'h0;
    assign rdata_valid = (state == ST_DONE) && is_load(op_q);

    mem_access_ctrl_load_align u_align (
        .op     (op_q),
        .off    (off_q),
        .raw    (ram_rdata),
        .result (aligned)
    );

    always_comb begin
        state_nx   = state;
        discard_nx = discard;
        stall      = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 4'h0;
        ram_addr   = 32'h0;
        ram_wdata  = 32'h0;
        bus_err_nx = 1'b0;
        load_done  = 1'b0;

        case (state)
            ST_IDLE: begin
                discard_nx = 1'b0;
                if (start) begin
                    stall     = 1'b1;
                    ram_en    = 1'b1;
                    ram_addr  = {addr[31:2], 2'b00};
                    ram_we    = store_strobe(op, addr[1:0]);
                    ram_wdata = store_data(op, wdata);
                    state_nx  = ram_addr_ok ? ST_WAIT : ST_REQ;
                end
            end
            ST_REQ: begin
                stall     = 1'b1;
                ram_en    = 1'b1;
                ram_addr  = addr_q;
                ram_we    = we_q;
                ram_wdata = wdata_q;
                // once the RAM has taken the request it must drain, so a flush only marks it
                if (ram_addr_ok) begin
                    state_nx = ST_WAIT;
                    if (flush) discard_nx = 1'b1;
                end else if (flush) begin
                    state_nx = ST_IDLE;
                end else if (timeout) begin
                    state_nx   = ST_IDLE;
                    bus_err_nx = 1'b1;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (flush) discard_nx = 1'b1;
                if (ram_data_ok) begin
                    discard_nx = 1'b0;
                    state_nx   = drop ? ST_IDLE : ST_DONE;
                    load_done  = !drop && is_load(op_q);
                end else if (timeout) begin
                    state_nx   = ST_IDLE;
                    discard_nx = 1'b0;
                    bus_err_nx = 1'b1;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            op_q    <= 6'h0;
            off_q   <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            we_q    <= 4'h0;
            discard <= 1'b0;
            wd_cnt  <= 8'h0;
            bus_err <= 1'b0;
            rdata   <= 32'h0;
        end else begin
            state   <= state_nx;
            discard <= discard_nx;
            bus_err <= bus_err_nx;
            wd_cnt  <= ((state == ST_REQ) || (state == ST_WAIT)) ? wd_cnt + 8'd1 : 8'h0;
            if (start) begin
                op_q    <= op;
                off_q   <= addr[1:0];
                addr_q  <= {addr[31:2], 2'b00};
                we_q    <= store_strobe(op, addr[1:0]);
                wdata_q <= store_data(op, wdata);
            end
            if (load_done) rdata <= aligned;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed vectors with hand-computed expectations for mem_access_ctrl
// Revision: 1.0
`default_nettype none

module tb_mem_access_ctrl;

    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SB  = 6'b101000;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SW  = 6'b101011;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_req, flush;
    logic [5:0]  op;
    logic [31:0] addr, wdata;
    logic        stall, rdata_valid, adel, ades, bus_err, ram_en;
    logic [31:0] rdata, bad_vaddr, ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_we;
    logic        ram_addr_ok, ram_data_ok;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.MAX_WAIT(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .mem_req     (mem_req),
        .op          (op),
        .addr        (addr),
        .wdata       (wdata),
        .flush       (flush),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .adel        (adel),
        .ades        (ades),
        .bad_vaddr   (bad_vaddr),
        .bus_err     (bus_err),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_addr_ok (ram_addr_ok),
        .ram_data_ok (ram_data_ok),
        .ram_rdata   (ram_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        mem_req = 1'b0; flush = 1'b0; ram_addr_ok = 1'b0; ram_data_ok = 1'b0;
    endtask

    task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d,
                         input logic aok);
        mem_req = 1'b1; op = o; addr = a; wdata = d; ram_addr_ok = aok;
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();
        op = LW; addr = 32'h1000; wdata = 32'h0; ram_rdata = 32'h0;
        mem_req = 1'b1;
        settle();
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_ram_en", {31'h0, ram_en}, 32'h0);
        check("rst_rvalid", {31'h0, rdata_valid}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_bus_err", {31'h0, bus_err}, 32'h0);
        tick();
        resetn = 1'b1;
        idle_inputs();
        tick();

        // LB from byte 3, one-cycle RAM
        issue(LB, 32'h1000_0003, 32'h0, 1'b1);
        settle();
        check("lb_stall_t0", {31'h0, stall}, 32'h1);
        check("lb_ram_en", {31'h0, ram_en}, 32'h1);
        check("lb_ram_addr", ram_addr, 32'h1000_0000);
        check("lb_ram_we", {28'h0, ram_we}, 32'h0);
        tick();
        idle_inputs(); ram_data_ok = 1'b1; ram_rdata = 32'h80FF_1234;
        settle();
        check("lb_stall_t1", {31'h0, stall}, 32'h1);
        check("lb_ram_en_t1", {31'h0, ram_en}, 32'h0);
        check("lb_rvalid_t1", {31'h0, rdata_valid}, 32'h0);
        tick();
        idle_inputs();
        settle();
        check("lb_rvalid_t2", {31'h0, rdata_valid}, 32'h1);
        check("lb_rdata", rdata, 32'hFFFF_FF80);
        check("lb_stall_t2", {31'h0, stall}, 32'h0);
        tick();
        settle();
        check("lb_rvalid_t3", {31'h0, rdata_valid}, 32'h0);

        // SH to upper half
        tick();
        issue(SH, 32'h0000_2002, 32'h0000_ABCD, 1'b1);
        settle();
        check("sh_ram_we", {28'h0, ram_we}, 32'hC);
        check("sh_ram_wdata", ram_wdata, 32'hABCD_ABCD);
        check("sh_ram_addr", ram_addr, 32'h0000_2000);
        tick();
        idle_inputs(); ram_data_ok = 1'b1;
        settle();
        check("sh_stall_t1", {31'h0, stall}, 32'h1);
        tick();
        idle_inputs();
        settle();
        check("sh_rvalid", {31'h0, rdata_valid}, 32'h0);
        check("sh_stall_done", {31'h0, stall}, 32'h0);
        check("sh_rdata_hold", rdata, 32'hFFFF_FF80);

        // SB strobe and replication
        tick();
        issue(SB, 32'h0000_9001, 32'h1234_565A, 1'b1);
        settle();
        check("sb_ram_we", {28'h0, ram_we}, 32'h2);
        check("sb_ram_wdata", ram_wdata, 32'h5A5A_5A5A);
        tick();
        idle_inputs(); ram_data_ok = 1'b1;
        tick();
        idle_inputs();
        tick();

        // misaligned accesses and an unrecognised opcode
        issue(LW, 32'h0000_3001, 32'h0, 1'b0);
        settle();
        check("lw_adel", {31'h0, adel}, 32'h1);
        check("lw_ades", {31'h0, ades}, 32'h0);
        check("lw_bad_vaddr", bad_vaddr, 32'h0000_3001);
        check("lw_mis_ram_en", {31'h0, ram_en}, 32'h0);
        check("lw_mis_stall", {31'h0, stall}, 32'h0);
        tick();
        issue(SW, 32'h0000_3002, 32'h0, 1'b0);
        settle();
        check("sw_ades", {31'h0, ades}, 32'h1);
        check("sw_adel", {31'h0, adel}, 32'h0);
        check("sw_bad_vaddr", bad_vaddr, 32'h0000_3002);
        check("sw_mis_ram_en", {31'h0, ram_en}, 32'h0);
        tick();
        issue(6'b000000, 32'h0000_3000, 32'h0, 1'b0);
        settle();
        check("bad_op_stall", {31'h0, stall}, 32'h0);
        check("bad_op_ram_en", {31'h0, ram_en}, 32'h0);
        check("bad_op_adel", {31'h0, adel}, 32'h0);
        tick();
        idle_inputs();
        settle();
        check("idle_after_ex", {31'h0, ram_en | stall}, 32'h0);

        // LHU with addr_ok three cycles late
        tick();
        issue(LHU, 32'h0000_4002, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("lhu_ram_en_%0d", i), {31'h0, ram_en}, 32'h1);
            check($sformatf("lhu_ram_addr_%0d", i), ram_addr, 32'h0000_4000);
            tick();
            idle_inputs();
            if (i == 2) ram_addr_ok = 1'b1;
        end
        ram_data_ok = 1'b1; ram_rdata = 32'h8765_4321;
        settle();
        check("lhu_ram_en_off", {31'h0, ram_en}, 32'h0);
        check("lhu_stall_wait", {31'h0, stall}, 32'h1);
        tick();
        idle_inputs();
        settle();
        check("lhu_rvalid", {31'h0, rdata_valid}, 32'h1);
        check("lhu_rdata", rdata, 32'h0000_8765);

        // flush while waiting for data: drains, no rdata_valid
        tick();
        issue(LW, 32'h0000_5000, 32'h0, 1'b1);
        tick();
        idle_inputs(); flush = 1'b1;
        settle();
        check("fw_stall_t1", {31'h0, stall}, 32'h1);
        tick();
        idle_inputs();
        settle();
        check("fw_stall_t2", {31'h0, stall}, 32'h1);
        tick();
        ram_data_ok = 1'b1; ram_rdata = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        settle();
        check("fw_rvalid", {31'h0, rdata_valid}, 32'h0);
        check("fw_stall_end", {31'h0, stall}, 32'h0);
        check("fw_rdata_hold", rdata, 32'h0000_8765);
        tick();
        settle();
        check("fw_rvalid_t5", {31'h0, rdata_valid}, 32'h0);

        // flush before addr_ok: request withdrawn
        tick();
        issue(LW, 32'h0000_6000, 32'h0, 1'b0);
        tick();
        idle_inputs(); flush = 1'b1;
        settle();
        check("fr_ram_en_t1", {31'h0, ram_en}, 32'h1);
        tick();
        idle_inputs();
        settle();
        check("fr_ram_en_t2", {31'h0, ram_en}, 32'h0);
        check("fr_stall_t2", {31'h0, stall}, 32'h0);

        // watchdog: data_ok never comes
        tick();
        issue(LW, 32'h0000_7000, 32'h0, 1'b1);
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("wd_stall_%0d", i), {31'h0, stall}, 32'h1);
            check($sformatf("wd_bus_err_%0d", i), {31'h0, bus_err}, 32'h0);
            tick();
        end
        ram_data_ok = 1'b1; ram_rdata = 32'hCAFE_0000;
        settle();
        check("wd_bus_err", {31'h0, bus_err}, 32'h1);
        check("wd_stall_off", {31'h0, stall}, 32'h0);
        tick();
        idle_inputs();
        settle();
        check("wd_bus_err_end", {31'h0, bus_err}, 32'h0);
        check("wd_late_rvalid", {31'h0, rdata_valid}, 32'h0);
        tick();
        issue(LW, 32'h0000_8000, 32'h0, 1'b1);
        settle();
        check("wd_next_ram_en", {31'h0, ram_en}, 32'h1);
        check("wd_next_stall", {31'h0, stall}, 32'h1);
        tick();
        idle_inputs(); ram_data_ok = 1'b1; ram_rdata = 32'h1234_5678;
        tick();
        idle_inputs();
        settle();
        check("wd_next_rvalid", {31'h0, rdata_valid}, 32'h1);
        check("wd_next_rdata", rdata, 32'h1234_5678);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
